sample_binner: RTL
==================

SAMPLE_BINNER -- requirements
Module: sample_binner

Interface
REQ-001 SHALL have parameter: WORDS_W, default 32, width of the run-length input and the internal remaining-word counter.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  single-cycle run request.
REQ-005 SHALL have port: num_words  input  WORDS_W  number of RNG words in the run; sampled only when start is accepted.
REQ-006 SHALL have port: rng_valid  input  1  rng_data valid.
REQ-007 SHALL have port: rng_data  input  20  four 5-bit samples; sample k = rng_data[5k+4:5k], k=0..3.
REQ-008 SHALL have port: rng_ready  output  1  block accepts rng_data this cycle.
REQ-009 SHALL have port: bin_cnt  output  3 x 32 (unpacked array [31:0])  per-bin hit count for one word, range 0..4.
REQ-010 SHALL have port: bin_en  output  1  bin_cnt valid; drives the histogram accumulator's enable.
REQ-011 SHALL have port: busy  output  1  high whenever state != IDLE.
REQ-012 SHALL have port: done  output  1  one-cycle pulse at run completion.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE: start=1 with num_words!=0 -> RUN, load remaining=num_words; start=1 with num_words==0 -> DONE; otherwise stay.
REQ-015 start SHALL be ignored in RUN, DRAIN, DONE.
REQ-016 rng_ready SHALL be 1 only in RUN (Moore, registered state, no combinational path from rng_valid).
REQ-017 Word accepted iff rng_valid && rng_ready; each accept decrements remaining by 1.
REQ-018 Accept with remaining==1 -> DRAIN next cycle; rng_ready deasserts that same next cycle; no extra word accepted.
REQ-019 Pipeline stage 1: register the 4 samples and a valid bit on accept.
REQ-020 Pipeline stage 2: bin_cnt[i] = number of stage-1 samples equal to i, registered; bin_en = registered stage-1 valid.
REQ-021 Latency: accept in cycle N -> bin_en=1 with that word's counts in cycle N+2; one bin_en cycle per accepted word, order preserved.
REQ-022 When bin_en=1, sum over i of bin_cnt[i] SHALL equal 4; when bin_en=0, every bin_cnt[i] SHALL be 0.
REQ-023 Back-to-back accepts (rng_valid held high) SHALL give one word per cycle, no bubbles.
REQ-024 rng_valid gaps SHALL produce matching bin_en gaps; no counts lost or duplicated.
REQ-025 DRAIN -> DONE when both pipeline-stage valid bits are 0, i.e. after the last bin_en has been emitted.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-027 Counters SHALL not wrap: remaining never decrements below 0; num_words=2^WORDS_W-1 SHALL be supported.
REQ-028 Total bin_en cycles in a run SHALL equal num_words; downstream total advances by 4 per bin_en.

Reset
REQ-029 rst=1 SHALL force state IDLE, remaining=0, pipeline valids=0, rng_ready=0, bin_en=0, all bin_cnt=0, busy=0, done=0 on the next clk edge.
REQ-030 rst asserted mid-run SHALL abort: in-flight words are discarded and no bin_en or done follows.
REQ-031 rst SHALL take priority over start and rng_valid in the same cycle.

Verification
REQ-032 Run num_words=1, rng_data={5'd3,5'd3,5'd0,5'd31} -> bin_en once, 2 cycles after accept; bin_cnt[3]=2, [0]=1, [31]=1, others 0; done pulses once; busy low after.
REQ-033 Run num_words=8, rng_valid held high, samples all 5'd7 -> 8 consecutive bin_en cycles with bin_cnt[7]=4; rng_ready low from the cycle after the 8th accept.
REQ-034 Run num_words=5, rng_valid toggling 1,0,1,0,... -> exactly 5 bin_en cycles, each 2 cycles after its accept; done only after the 5th.
REQ-035 start with num_words=0 -> no rng_ready, no bin_en; done pulses 2 cycles after start; back to IDLE.
REQ-036 rst for 1 cycle after 3 of 10 words accepted -> all outputs 0 next cycle; no further bin_en or done; a new start runs normally.
REQ-037 Random run of 1000 words, scoreboard -> per-bin sums match the reference model; sum(bin_cnt)=4 on every bin_en; start pulses during RUN ignored.

Source files
------------

// File: rtl/sample_binner.sv
// sample_binner: consumes a run of RNG words (four 5-bit samples each)
// and emits, two cycles after each accepted word, a per-bin hit count
// for that word across 32 bins, used as the enable/data of a histogram
// accumulator downstream.
module sample_binner #(
    parameter int WORDS_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WORDS_W-1:0] num_words,
    input  logic               rng_valid,
    input  logic [19:0]        rng_data,
    output logic               rng_ready,
    output logic [2:0]         bin_cnt [31:0],
    output logic               bin_en,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WORDS_W-1:0] remaining_q, remaining_d;
    logic               done_q;

    // Stage 1: captured samples of the accepted word
    logic               s1_valid_q;
    logic [4:0]         s1_sample_q [4];

    // Stage 2: per-bin counts presented downstream
    logic               s2_valid_q;
    logic [2:0]         s2_cnt_q [32];
    logic [2:0]         cnt_d [32];

    logic               accept;

    // Ready depends only on registered state, never on rng_valid
    assign rng_ready = (state_q == RUN);
    assign accept    = rng_valid && rng_ready;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign bin_en    = s2_valid_q;

    // Run-control next state: load the word count, count accepts down,
    // then wait for the pipeline to empty before signalling completion
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_words != '0) begin
                        state_d     = RUN;
                        remaining_d = num_words;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    remaining_d = remaining_q - WORDS_W'(1);
                    if (remaining_q == WORDS_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!s1_valid_q && !s2_valid_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Run-control state and remaining-word counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    // Completion pulse is registered off the DONE state, one cycle long
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == DONE);
        end
    end

    // Stage 1: capture the four samples of each accepted word
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= accept;
        end
        if (accept) begin
            for (int k = 0; k < 4; k++) begin
                s1_sample_q[k] <= rng_data[5*k +: 5];
            end
        end
    end

    // Per-bin hit count: how many of the four captured samples equal the bin index
    for (genvar gi = 0; gi < 32; gi++) begin : g_bin
        logic [3:0] hit;
        for (genvar gk = 0; gk < 4; gk++) begin : g_smp
            assign hit[gk] = (s1_sample_q[gk] == 5'(gi));
        end
        assign cnt_d[gi] = {2'b00, hit[0]} + {2'b00, hit[1]}
                         + {2'b00, hit[2]} + {2'b00, hit[3]};
        assign bin_cnt[gi] = s2_cnt_q[gi];
    end

    // Stage 2: register counts; bins are forced to zero when no word is present
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                s2_cnt_q[i] <= 3'd0;
            end
        end else begin
            s2_valid_q <= s1_valid_q;
            for (int i = 0; i < 32; i++) begin
                s2_cnt_q[i] <= s1_valid_q ? cnt_d[i] : 3'd0;
            end
        end
    end

endmodule
